branch_pred_tracker: RTL and testbench

- Carries per-branch prediction metadata from fetch to the EX/MEM resolution point. Sits between the tournament predictor and the pipeline.
- Queues in-flight conditional-branch predictions: pc, final direction, local direction, global direction.
- At resolution, compares the oldest entry against the actual outcome and drives the predictor's ex_mem_* update inputs plus a mispredict flush.
- It is the producer side of the predictor's update interface; the predictor consumes these signals.

---
 rtl/br_pkg.sv | 13 +
 rtl/branch_pred_tracker_if.sv | 48 ++++
 rtl/br_meta_fifo.sv | 66 ++++++
 rtl/branch_pred_tracker.sv | 119 +++++++++++
 tb/tb_branch_pred_tracker.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/br_pkg.sv
// Shared types for the branch prediction tracker: branch opcode and per-branch metadata.
package br_pkg;

  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic [31:0] pc;
    logic        predict_dir;
    logic        lc_dir;
    logic        gl_dir;
  } br_meta_t;

endpackage

// File: rtl/branch_pred_tracker_if.sv
// Fetch, resolve and predictor-update signals of the tracker.
// BR_TRACK_STATS_EN adds the br_count / mispred_count counters.
interface branch_pred_tracker_if;

  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic        if_predict_dir;
  logic        if_lc_dir;
  logic        if_gl_dir;
  logic        full;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_br_en;
  logic        ex_mem_br_en;
  logic [31:0] ex_mem_pc;
  logic [6:0]  ex_mem_opcode;
  logic        ex_mem_lc_dir;
  logic        ex_mem_gl_dir;
  logic        mispredict;
  logic        tag_err;
`ifdef BR_TRACK_STATS_EN
  logic [31:0] br_count;
  logic [31:0] mispred_count;
`endif

  modport master (
`ifdef BR_TRACK_STATS_EN
    input  br_count, mispred_count,
`endif
    output stall, if_valid, if_pc, if_opcode, if_predict_dir, if_lc_dir, if_gl_dir,
    output res_valid, res_pc, res_br_en,
    input  full, ex_mem_br_en, ex_mem_pc, ex_mem_opcode, ex_mem_lc_dir, ex_mem_gl_dir,
    input  mispredict, tag_err
  );

  modport slave (
`ifdef BR_TRACK_STATS_EN
    output br_count, mispred_count,
`endif
    input  stall, if_valid, if_pc, if_opcode, if_predict_dir, if_lc_dir, if_gl_dir,
    input  res_valid, res_pc, res_br_en,
    output full, ex_mem_br_en, ex_mem_pc, ex_mem_opcode, ex_mem_lc_dir, ex_mem_gl_dir,
    output mispredict, tag_err
  );

endinterface

// File: rtl/br_meta_fifo.sv
// Circular buffer of in-flight branch metadata with push/pop and a flush that empties it.
module br_meta_fifo
  import br_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  logic     pop_i,
  input  logic     flush_i,
  input  br_meta_t wdata_i,
  output br_meta_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  br_meta_t             mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: only slots counted as occupied are ever read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_pred_tracker.sv
// Tracks in-flight branch predictions and issues predictor updates, mispredict flush and tag errors.
// BR_TRACK_STATS_EN adds saturating update / mispredict counters.
module branch_pred_tracker
  import br_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_pred_tracker_if.slave  bus
);

  br_meta_t    head;
  br_meta_t    wdata;
  logic        fifo_full, fifo_empty;
  logic        push, pop, mis;

  logic [6:0]  opcode_q, opcode_d;
  logic        br_en_q, br_en_d;
  logic [31:0] pc_q, pc_d;
  logic        lc_q, lc_d;
  logic        gl_q, gl_d;
  logic        mis_q, mis_d;
  logic        tag_q, tag_d;

  // A mispredicting pop flushes the queue and drops any same-cycle (wrong-path) push.
  always_comb begin
    pop   = bus.res_valid & ~bus.stall & ~fifo_empty;
    mis   = pop & (head.predict_dir != bus.res_br_en);
    push  = bus.if_valid & ~bus.stall & (bus.if_opcode == OP_BR) & (~fifo_full | pop) & ~mis;
    wdata = '{pc: bus.if_pc, predict_dir: bus.if_predict_dir,
              lc_dir: bus.if_lc_dir, gl_dir: bus.if_gl_dir};
  end

  br_meta_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (mis),
    .wdata_i (wdata),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    opcode_d = '0;
    br_en_d  = br_en_q;
    pc_d     = pc_q;
    lc_d     = lc_q;
    gl_d     = gl_q;
    mis_d    = mis;
    tag_d    = (bus.res_valid & ~bus.stall & fifo_empty) | (pop & (bus.res_pc != head.pc));
    if (pop) begin
      opcode_d = OP_BR;
      br_en_d  = bus.res_br_en;
      pc_d     = head.pc;
      lc_d     = head.lc_dir;
      gl_d     = head.gl_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      opcode_q <= '0;
      br_en_q  <= 1'b0;
      pc_q     <= '0;
      lc_q     <= 1'b0;
      gl_q     <= 1'b0;
      mis_q    <= 1'b0;
      tag_q    <= 1'b0;
    end else begin
      opcode_q <= opcode_d;
      br_en_q  <= br_en_d;
      pc_q     <= pc_d;
      lc_q     <= lc_d;
      gl_q     <= gl_d;
      mis_q    <= mis_d;
      tag_q    <= tag_d;
    end
  end

  assign bus.full          = fifo_full;
  assign bus.ex_mem_opcode = opcode_q;
  assign bus.ex_mem_br_en  = br_en_q;
  assign bus.ex_mem_pc     = pc_q;
  assign bus.ex_mem_lc_dir = lc_q;
  assign bus.ex_mem_gl_dir = gl_q;
  assign bus.mispredict    = mis_q;
  assign bus.tag_err       = tag_q;

`ifdef BR_TRACK_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  // Counters advance with the update they describe and stick at all-ones.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (pop && (br_cnt_q != '1))  br_cnt_d  = br_cnt_q + 32'd1;
    if (mis && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign bus.br_count      = br_cnt_q;
  assign bus.mispred_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pred_tracker.sv
// Bench for branch_pred_tracker: directed scenarios with literal expectations plus random traffic
// checked every cycle against a queue-based model.
module tb_branch_pred_tracker;
  import br_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_pred_tracker_if bus ();

  branch_pred_tracker #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of outstanding predictions.
  br_meta_t    mq[$];
  br_meta_t    h;
  bit          started = 0;
  bit          popped, was_full;
  logic [6:0]  exp_opcode;
  logic        exp_br_en, exp_lc, exp_gl, exp_mis, exp_tag, exp_full;
  logic [31:0] exp_pc;
  logic [31:0] exp_br_cnt, exp_mis_cnt;

  always @(posedge clk) begin
    started = 1;
    if (!rst) begin
      mq.delete();
      exp_opcode = 0; exp_br_en = 0; exp_pc = 0; exp_lc = 0; exp_gl = 0;
      exp_mis = 0; exp_tag = 0; exp_full = 0; exp_br_cnt = 0; exp_mis_cnt = 0;
    end else begin
      popped = 0;
      was_full = (mq.size() == DEPTH);
      exp_opcode = 0; exp_mis = 0; exp_tag = 0;
      if (bus.res_valid && !bus.stall) begin
        if (mq.size() == 0) exp_tag = 1;
        else begin
          h = mq.pop_front();
          popped = 1;
          exp_opcode = OP_BR;
          exp_br_en = bus.res_br_en;
          exp_pc = h.pc; exp_lc = h.lc_dir; exp_gl = h.gl_dir;
          exp_mis = (h.predict_dir != bus.res_br_en);
          exp_tag = (bus.res_pc != h.pc);
          if (exp_br_cnt != 32'hFFFF_FFFF) exp_br_cnt++;
          if (exp_mis && exp_mis_cnt != 32'hFFFF_FFFF) exp_mis_cnt++;
        end
      end
      if (exp_mis) mq.delete();
      else if (bus.if_valid && !bus.stall && bus.if_opcode == OP_BR && (!was_full || popped))
        mq.push_back('{pc: bus.if_pc, predict_dir: bus.if_predict_dir,
                       lc_dir: bus.if_lc_dir, gl_dir: bus.if_gl_dir});
      exp_full = (mq.size() == DEPTH);
    end
  end

  // Compare every cycle, mid-period, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("opcode",     32'(bus.ex_mem_opcode), 32'(exp_opcode));
      chk("br_en",      32'(bus.ex_mem_br_en),  32'(exp_br_en));
      chk("pc",         bus.ex_mem_pc,          exp_pc);
      chk("lc_dir",     32'(bus.ex_mem_lc_dir), 32'(exp_lc));
      chk("gl_dir",     32'(bus.ex_mem_gl_dir), 32'(exp_gl));
      chk("mispredict", 32'(bus.mispredict),    32'(exp_mis));
      chk("tag_err",    32'(bus.tag_err),       32'(exp_tag));
      chk("full",       32'(bus.full),          32'(exp_full));
`ifdef BR_TRACK_STATS_EN
      chk("br_count",      bus.br_count,      exp_br_cnt);
      chk("mispred_count", bus.mispred_count, exp_mis_cnt);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1;
    bus.stall = 0; bus.if_valid = 0; bus.if_pc = 0; bus.if_opcode = 0;
    bus.if_predict_dir = 0; bus.if_lc_dir = 0; bus.if_gl_dir = 0;
    bus.res_valid = 0; bus.res_pc = 0; bus.res_br_en = 0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pd, input logic lc, input logic gl);
    bus.if_valid = 1; bus.if_opcode = OP_BR; bus.if_pc = pc;
    bus.if_predict_dir = pd; bus.if_lc_dir = lc; bus.if_gl_dir = gl;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic ben);
    bus.res_valid = 1; bus.res_pc = pc; bus.res_br_en = ben;
  endtask

  task automatic push1(input logic [31:0] pc, input logic pd);
    idle(); set_push(pc, pd, 0, 0); cyc();
  endtask

  task automatic res1(input logic [31:0] pc, input logic ben);
    idle(); set_res(pc, ben); cyc();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    cyc(); cyc();
    chk("rst_opcode", 32'(bus.ex_mem_opcode), 32'h0);
    chk("rst_pc",     bus.ex_mem_pc,          32'h0);
    chk("rst_full",   32'(bus.full),          32'h0);
    chk("rst_mis",    32'(bus.mispredict),    32'h0);

    // Correct prediction
    idle(); set_push(32'h100, 1, 1, 0); cyc();
    res1(32'h100, 1);
    chk("ok_opcode", 32'(bus.ex_mem_opcode), 32'h63);
    chk("ok_pc",     bus.ex_mem_pc,          32'h100);
    chk("ok_lc",     32'(bus.ex_mem_lc_dir), 32'h1);
    chk("ok_gl",     32'(bus.ex_mem_gl_dir), 32'h0);
    chk("ok_mis",    32'(bus.mispredict),    32'h0);
    idle(); cyc();
    chk("ok_pulse_end", 32'(bus.ex_mem_opcode), 32'h0);
    chk("ok_pc_hold",   bus.ex_mem_pc,          32'h100);

    // Mispredict flush with a wrong-path push in the same cycle
    push1(32'h10, 0); push1(32'h20, 0); push1(32'h30, 0);
    idle(); set_res(32'h10, 1); set_push(32'h40, 0, 0, 0); cyc();
    chk("mp_mis", 32'(bus.mispredict), 32'h1);
    chk("mp_pc",  bus.ex_mem_pc,       32'h10);
    res1(32'h20, 0);
    chk("mp_tag",    32'(bus.tag_err),       32'h1);
    chk("mp_no_upd", 32'(bus.ex_mem_opcode), 32'h0);

    // Full and pointer wrap
    push1(32'h200, 1); push1(32'h210, 1); push1(32'h220, 1); push1(32'h230, 1);
    chk("fw_full", 32'(bus.full), 32'h1);
    push1(32'h240, 1);
    chk("fw_full_ignored", 32'(bus.full), 32'h1);
    idle(); set_push(32'h250, 1, 0, 1); set_res(32'h200, 1); cyc();
    chk("fw_pushpop_full", 32'(bus.full), 32'h1);
    chk("fw_pc0", bus.ex_mem_pc, 32'h200);
    res1(32'h210, 1); chk("fw_pc1", bus.ex_mem_pc, 32'h210);
    res1(32'h220, 1); chk("fw_pc2", bus.ex_mem_pc, 32'h220);
    res1(32'h230, 1); chk("fw_pc3", bus.ex_mem_pc, 32'h230);
    res1(32'h250, 1); chk("fw_pc4", bus.ex_mem_pc, 32'h250);
    chk("fw_gl4", 32'(bus.ex_mem_gl_dir), 32'h1);

    // Stall
    push1(32'h300, 0);
    for (int i = 0; i < 3; i++) begin
      idle(); bus.stall = 1; set_push(32'h310, 0, 0, 0); set_res(32'h300, 0); cyc();
      chk("st_no_upd", 32'(bus.ex_mem_opcode), 32'h0);
      chk("st_no_tag", 32'(bus.tag_err),       32'h0);
    end
    res1(32'h300, 0);
    chk("st_upd", 32'(bus.ex_mem_opcode), 32'h63);
    chk("st_pc",  bus.ex_mem_pc,          32'h300);
    res1(32'h310, 0);
    chk("st_empty_tag", 32'(bus.tag_err), 32'h1);

    // Error cases
    res1(32'h999, 1);
    chk("err_empty_tag", 32'(bus.tag_err),       32'h1);
    chk("err_empty_op",  32'(bus.ex_mem_opcode), 32'h0);
    push1(32'h40, 1);
    res1(32'h44, 1);
    chk("err_pc_op",  32'(bus.ex_mem_opcode), 32'h63);
    chk("err_pc_pc",  bus.ex_mem_pc,          32'h40);
    chk("err_pc_tag", 32'(bus.tag_err),       32'h1);

    // Reset mid-operation
    push1(32'h500, 1);
    idle(); rst = 1'b0; cyc();
    chk("mr_pc",  bus.ex_mem_pc, 32'h0);
    res1(32'h500, 1);
    chk("mr_tag", 32'(bus.tag_err), 32'h1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.if_valid = ($urandom_range(0, 1) == 1);
      bus.if_opcode = ($urandom_range(0, 3) != 0) ? OP_BR : 7'($urandom);
      bus.if_pc = $urandom & 32'hFFFF_FFFC;
      bus.if_predict_dir = 1'($urandom); bus.if_lc_dir = 1'($urandom); bus.if_gl_dir = 1'($urandom);
      bus.res_valid = ($urandom_range(0, 9) < 4);
      if (mq.size() > 0) begin
        bus.res_pc = ($urandom_range(0, 7) != 0) ? mq[0].pc : $urandom;
        bus.res_br_en = ($urandom_range(0, 4) == 0) ? ~mq[0].predict_dir : mq[0].predict_dir;
      end else begin
        bus.res_pc = $urandom;
        bus.res_br_en = 1'($urandom);
      end
      cyc();
    end
    idle(); cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
